instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the program memory: owns the program counter, drives the memory address, and registers the returned 16-bit word into an instruction register for the decode stage. It handles stalls, jump redirects from execute with one-cycle squash, HALT detection, and a saturating fetch counter. Memory read is combinational, so fetch has a single-cycle PC-to-IR latency.

---
 rtl/instr_fetch.sv | 92 +++++++++
 tb/tb_instr_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, program-memory address and instruction
// register for the decode stage. The memory read is combinational, so a word
// addressed by pc lands in ir on the next rising edge. The design has two
// modes, RUN and HALTED, and the halted flop is the whole mode encoding.
module instr_fetch #(
  parameter int unsigned A_BITS  = 5,
  // Opcode field instr[15:9] that identifies HALT in the instruction set.
  parameter logic [6:0]  HALT_OP = 7'h7F
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [A_BITS-1:0] pc,
  input  logic [15:0]       instr_in,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [A_BITS-1:0] jump_target,
  output logic [15:0]       ir,
  output logic [A_BITS-1:0] ir_pc,
  output logic              ir_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic              is_halt;
  logic [A_BITS-1:0] pc_d;
  logic [15:0]       ir_d;
  logic [A_BITS-1:0] ir_pc_d;
  logic              ir_valid_d;
  logic              halted_d;
  logic [15:0]       fetch_count_d;

  // Decode the HALT opcode on the word currently returned for pc.
  assign is_halt = (instr_in[15:9] == HALT_OP);

  // Next-state selection: halted, then jump, then stall, then normal fetch.
  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    pc_d          = pc;
    ir_d          = ir;
    ir_pc_d       = ir_pc;
    ir_valid_d    = ir_valid;
    halted_d      = halted;
    fetch_count_d = fetch_count;

    if (halted) begin
      // Frozen until reset; only the valid flag drops.
      ir_valid_d = 1'b0;
    end else if (jump_en) begin
      // Redirect and squash the wrong-path word at pc (HALT included).
      pc_d       = jump_target;
      ir_valid_d = 1'b0;
    end else if (!stall) begin
      ir_d       = instr_in;
      ir_pc_d    = pc;
      ir_valid_d = 1'b1;
      if (fetch_count != COUNT_MAX) begin
        fetch_count_d = fetch_count + 16'd1;
      end
      if (is_halt) begin
        halted_d = 1'b1;
      end else begin
        // Wraps modulo 2^A_BITS with no flag.
        pc_d = pc + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      pc          <= '0;
      ir          <= 16'h0000;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      pc          <= pc_d;
      ir          <= ir_d;
      ir_pc       <= ir_pc_d;
      ir_valid    <= ir_valid_d;
      halted      <= halted_d;
      fetch_count <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational program memory model.
module tb_instr_fetch;

  localparam int unsigned A_BITS = 5;
  localparam logic [15:0] HALT_W = 16'hFE00; // opcode field 7'h7F
  localparam logic [15:0] ADD_W  = 16'h2A02;

  logic              clk;
  logic              rst_n;
  logic [A_BITS-1:0] pc;
  logic [15:0]       instr_in;
  logic              stall;
  logic              jump_en;
  logic [A_BITS-1:0] jump_target;
  logic [15:0]       ir;
  logic [A_BITS-1:0] ir_pc;
  logic              ir_valid;
  logic              halted;
  logic [15:0]       fetch_count;

  logic [15:0] mem [32];
  assign instr_in = mem[pc];

  int errors = 0;
  int checks = 0;

  instr_fetch #(.A_BITS(A_BITS), .HALT_OP(7'h7F)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr_in(instr_in),
    .stall(stall), .jump_en(jump_en), .jump_target(jump_target),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pc"}, 32'(pc), 0);
    check({tag, ".ir"}, 32'(ir), 0);
    check({tag, ".ir_pc"}, 32'(ir_pc), 0);
    check({tag, ".ir_valid"}, 32'(ir_valid), 0);
    check({tag, ".halted"}, 32'(halted), 0);
    check({tag, ".count"}, 32'(fetch_count), 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 | 16'(i);
    mem[2] = ADD_W;
    mem[5] = HALT_W;
    rst_n = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_target = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    rst_n = 1'b1;

    // Free run to HALT at address 5.
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("run.ir_pc%0d", k), 32'(ir_pc), k);
      check($sformatf("run.valid%0d", k), 32'(ir_valid), 1);
      check($sformatf("run.ir%0d", k), 32'(ir), 32'(mem[k]));
    end
    check("halt.halted", 32'(halted), 1);
    check("halt.count", 32'(fetch_count), 6);
    check("halt.pc", 32'(pc), 5);
    step();
    check("halt.valid0", 32'(ir_valid), 0);
    check("halt.pc_hold", 32'(pc), 5);
    check("halt.count_hold", 32'(fetch_count), 6);
    // Jump and stall ignored while halted.
    jump_en = 1'b1; jump_target = 5'd9; stall = 1'b1;
    step();
    check("halt.jump_ign", 32'(pc), 5);
    check("halt.ir_pc_hold", 32'(ir_pc), 5);
    jump_en = 1'b0; stall = 1'b0;

    // Reset while halted, asynchronously.
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_halt");
    mem[5] = 16'h1005;
    rst_n = 1'b1;
    step();
    check("rel.ir", 32'(ir), 32'h1000);
    check("rel.valid", 32'(ir_valid), 1);
    check("rel.pc", 32'(pc), 1);
    repeat (3) step();
    check("pre_stall.ir_pc", 32'(ir_pc), 3);
    check("pre_stall.count", 32'(fetch_count), 4);

    // Stall three cycles while ir_pc=3.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall.ir_pc%0d", k), 32'(ir_pc), 3);
      check($sformatf("stall.ir%0d", k), 32'(ir), 32'h1003);
      check($sformatf("stall.pc%0d", k), 32'(pc), 4);
      check($sformatf("stall.cnt%0d", k), 32'(fetch_count), 4);
      check($sformatf("stall.valid%0d", k), 32'(ir_valid), 1);
    end
    stall = 1'b0;
    step();
    check("unstall.ir_pc", 32'(ir_pc), 4);
    check("unstall.count", 32'(fetch_count), 5);
    check("unstall.pc", 32'(pc), 5);

    // Reset in the middle of a stall; outputs stay at reset through an edge.
    stall = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_stall");
    step();
    check("rst_hold.pc", 32'(pc), 0);
    stall = 1'b0;
    rst_n = 1'b1;

    // Jump to 17, fetch it, then jump to 20 from pc=18.
    jump_en = 1'b1; jump_target = 5'd17;
    step();
    check("j17.pc", 32'(pc), 17);
    check("j17.count", 32'(fetch_count), 0);
    jump_en = 1'b0;
    step();
    check("f17.ir_pc", 32'(ir_pc), 17);
    check("f17.pc", 32'(pc), 18);
    jump_en = 1'b1; jump_target = 5'd20;
    step();
    check("j20.pc", 32'(pc), 20);
    check("j20.valid", 32'(ir_valid), 0);
    check("j20.ir_pc_hold", 32'(ir_pc), 17);
    check("j20.count", 32'(fetch_count), 1);
    jump_en = 1'b0;
    step();
    check("f20.ir_pc", 32'(ir_pc), 20);
    check("f20.ir", 32'(ir), 32'h1014);
    check("f20.valid", 32'(ir_valid), 1);
    check("f20.count", 32'(fetch_count), 2);

    // Jump together with stall: jump wins.
    jump_en = 1'b1; stall = 1'b1; jump_target = 5'd10;
    step();
    check("js.pc", 32'(pc), 10);
    check("js.valid", 32'(ir_valid), 0);
    jump_en = 1'b0; stall = 1'b0;
    step();
    check("js.ir_pc", 32'(ir_pc), 10);
    check("js.count", 32'(fetch_count), 3);

    // Jump while a HALT word sits at pc=11: HALT is squashed.
    mem[11] = HALT_W;
    jump_en = 1'b1; jump_target = 5'd25;
    step();
    check("jh.halted", 32'(halted), 0);
    check("jh.pc", 32'(pc), 25);
    jump_en = 1'b0;
    step();
    check("jh.ir_pc", 32'(ir_pc), 25);
    check("jh.count", 32'(fetch_count), 4);

    // Wrap from 31 to 0.
    jump_en = 1'b1; jump_target = 5'd31;
    step();
    check("wrap.pc31", 32'(pc), 31);
    jump_en = 1'b0;
    step();
    check("wrap.pc", 32'(pc), 0);
    check("wrap.ir_pc", 32'(ir_pc), 31);
    check("wrap.count", 32'(fetch_count), 5);

    // A jump pulse between edges is not sampled.
    #2 jump_en = 1'b1; jump_target = 5'd7;
    #2 jump_en = 1'b0;
    step();
    check("glitch.pc", 32'(pc), 1);
    check("glitch.ir_pc", 32'(ir_pc), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
